nf10_axis_rr_arbiter: RTL and testbench
=======================================

# nf10_axis_rr_arbiter

Packet-granular round-robin arbiter that merges C_NUM_PORTS AXI4-Stream slave inputs onto one master stream. It sits upstream of the width converter, so several MAC/DMA sources share a single converter and datapath. Whole packets are never interleaved, and TUSER metadata travels with the granted packet unchanged.

## Interface
Parameters:
- C_NUM_PORTS, 4: number of slave streams, 2..8.
- C_DATA_WIDTH, 256: TDATA width on all ports, bits.
- C_USER_WIDTH, 128: TUSER width on all ports.

Ports:
- axi_aclk  in  1  single clock; all logic on the rising edge.
- axi_resetn  in  1  synchronous, active-low reset.
- s_axis_tdata  in  C_NUM_PORTS*C_DATA_WIDTH  port p at slice [p*C_DATA_WIDTH +: C_DATA_WIDTH].
- s_axis_tstrb  in  C_NUM_PORTS*C_DATA_WIDTH/8  byte strobes, same slicing.
- s_axis_tuser  in  C_NUM_PORTS*C_USER_WIDTH  per-port metadata, sampled with each beat.
- s_axis_tvalid  in  C_NUM_PORTS  per-port valid.
- s_axis_tready  out  C_NUM_PORTS  per-port ready.
- s_axis_tlast  in  C_NUM_PORTS  per-port end of packet.
- m_axis_tdata  out  C_DATA_WIDTH  merged data.
- m_axis_tstrb  out  C_DATA_WIDTH/8  merged strobes.
- m_axis_tuser  out  C_USER_WIDTH  metadata of the granted port.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  merged end of packet.
- grant  out  log2(C_NUM_PORTS)  currently or last granted port, for debug and statistics.
- busy  out  1  high while the arbiter is in state PKT.

## Operation
- State machine with two states, IDLE and PKT. Registers: state, grant, last_grant.
- IDLE:
  - Drive m_axis_tvalid=0 and all s_axis_tready=0.
  - If any s_axis_tvalid is high, select the first valid port scanning last_grant+1, last_grant+2, … modulo C_NUM_PORTS.
  - Register the selection into grant and move to PKT.
  - If no port is valid, stay in IDLE.
- PKT:
  - Combinationally drive the m_axis_* signals from the slice selected by grant.
  - m_axis_tvalid = s_axis_tvalid[grant]; s_axis_tready[grant] = m_axis_tready; every other tready is 0.
  - When the tlast beat is accepted (valid & ready & tlast): last_grant<=grant, state<=IDLE.
- Other ports' tvalid has no effect during PKT. If the granted port drops tvalid mid-packet, the arbiter holds the grant and the master output bubbles.
- Selection is combinational and depends only on tvalid and last_grant. It must not combinationally depend on m_axis_tready.
- grant and last_grant are modulo C_NUM_PORTS. Wrap from C_NUM_PORTS-1 to 0 is required, including for non-power-of-two port counts.

## Timing
- Reset values: state=IDLE, grant=0, last_grant=C_NUM_PORTS-1 (so port 0 has first priority), busy=0, m_axis_tvalid=0, m_axis_tlast=0, all s_axis_tready=0.
- Latency: first beat of a packet is presented on the master one cycle after its tvalid is seen in IDLE. Data path is zero-latency thereafter, with no registers on data.
- Every packet is followed by exactly one IDLE cycle. Peak throughput is N beats per N+1 cycles.
- Single-beat packet: PKT lasts one cycle if accepted immediately.
- Reset asserted mid-packet: the next cycle is in IDLE with reset values. The remainder of the partial packet is the upstream's concern.
- m_axis_tready low holds all outputs stable, as the AXI rule requires because the sources are stable.

## Structure
- Shared package nf10_axis_arb_pkg holds:
  - the state encodings IDLE=1'b0 and PKT=1'b1;
  - the log2 function, used for the grant width.
- One sub-module, nf10_rr_pick: combinational rotating priority encoder.
  - Inputs: valid vector, last pointer.
  - Outputs: next index, any_valid.
- The top level holds the FSM, grant registers and output muxes.

## Test plan
- Single port: port 2 sends a 3-beat packet, m_axis_tready=1 → m_axis_tvalid is high for 3 consecutive cycles starting one cycle after s_tvalid[2]; grant=2; tlast on beat 3; busy then falls.
- All four ports continuously valid, 2-beat packets → output grant order 0,1,2,3,0,…; exactly one idle cycle between packets; no interleaved beats.
- Ports 1 and 3 valid, last_grant=3 → port 1 is granted first, then port 3. The wrap 3→0→1 skips idle port 0.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 4-beat packet → outputs are stable while tready is low; s_axis_tready[grant] mirrors m_axis_tready; all 4 beats arrive with matching TUSER.
- Granted port drops tvalid for 2 cycles mid-packet while port 0 is valid → grant holds and port 0 is not served until the granted tlast beat is accepted.
- axi_resetn asserted on beat 2 of a 5-beat packet → next cycle m_axis_tvalid=0, s_axis_tready=0, grant=0, and port 0 has first priority.

Source files
------------

// File: rtl/nf10_axis_arb_pkg.sv
// Shared definitions for the packet round-robin AXI4-Stream arbiter:
// FSM state encoding and the index-width helper.
package nf10_axis_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } arb_state_t;

    // Bits needed to index n ports; never less than one bit.
    function automatic int log2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/nf10_rr_pick.sv
// Rotating priority encoder: first valid index after `last`, wrapping
// modulo C_NUM_PORTS (also for non-power-of-two port counts).
module nf10_rr_pick #(
    parameter int C_NUM_PORTS = 4,
    parameter int C_IDX_WIDTH = 2
) (
    input  logic [C_NUM_PORTS-1:0] valid,
    input  logic [C_IDX_WIDTH-1:0] last,
    output logic [C_IDX_WIDTH-1:0] next,
    output logic                   any_valid
);

    always_comb begin
        int idx;
        idx       = 0;
        next      = '0;
        any_valid = 1'b0;
        // last itself is scanned last, so a lone requester still wins.
        for (int k = 1; k <= C_NUM_PORTS; k++) begin
            idx = (int'(last) + k) % C_NUM_PORTS;
            if (!any_valid && valid[idx]) begin
                next      = C_IDX_WIDTH'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nf10_axis_rr_arbiter.sv
// Packet-granular round-robin merge of C_NUM_PORTS AXI4-Stream slaves onto
// one master. Whole packets only; the data path is a pure mux on grant.
module nf10_axis_rr_arbiter
    import nf10_axis_arb_pkg::*;
#(
    parameter int C_NUM_PORTS  = 4,
    parameter int C_DATA_WIDTH = 256,
    parameter int C_USER_WIDTH = 128
) (
    input  logic                                  axi_aclk,
    input  logic                                  axi_resetn,
    input  logic [C_NUM_PORTS*C_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_NUM_PORTS*C_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [C_NUM_PORTS*C_USER_WIDTH-1:0]   s_axis_tuser,
    input  logic [C_NUM_PORTS-1:0]                s_axis_tvalid,
    output logic [C_NUM_PORTS-1:0]                s_axis_tready,
    input  logic [C_NUM_PORTS-1:0]                s_axis_tlast,
    output logic [C_DATA_WIDTH-1:0]               m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]             m_axis_tstrb,
    output logic [C_USER_WIDTH-1:0]               m_axis_tuser,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tlast,
    output logic [log2(C_NUM_PORTS)-1:0]          grant,
    output logic                                  busy
);

    localparam int GW = log2(C_NUM_PORTS);
    localparam int SW = C_DATA_WIDTH / 8;

    // Handshake: a beat moves on any rising edge where tvalid && tready; a
    // source holds its beat stable until then, and tvalid never waits on tready.

    arb_state_t    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [GW-1:0] pick_idx;
    logic          pick_any;
    logic          pkt_active;
    logic          last_beat_done;

    nf10_rr_pick #(
        .C_NUM_PORTS (C_NUM_PORTS),
        .C_IDX_WIDTH (GW)
    ) u_pick (
        .valid     (s_axis_tvalid),
        .last      (last_grant_q),
        .next      (pick_idx),
        .any_valid (pick_any)
    );

    assign pkt_active = (state_q == ST_PKT);

    always_comb begin
        m_axis_tdata  = s_axis_tdata[int'(grant_q)*C_DATA_WIDTH +: C_DATA_WIDTH];
        m_axis_tstrb  = s_axis_tstrb[int'(grant_q)*SW +: SW];
        m_axis_tuser  = s_axis_tuser[int'(grant_q)*C_USER_WIDTH +: C_USER_WIDTH];
        m_axis_tvalid = pkt_active & s_axis_tvalid[grant_q];
        m_axis_tlast  = pkt_active & s_axis_tlast[grant_q];
        s_axis_tready = '0;
        if (pkt_active) begin
            s_axis_tready[grant_q] = m_axis_tready;
        end
    end

    assign last_beat_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // Selection only looks at tvalid and last_grant, never at m_axis_tready.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = ST_PKT;
                end
            end
            ST_PKT: begin
                if (last_beat_done) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(C_NUM_PORTS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign grant = grant_q;
    assign busy  = pkt_active;

endmodule

// File: tb/tb_nf10_axis_rr_arbiter.sv
// Bench for nf10_axis_rr_arbiter: per-port packet sources, a round-robin
// packet-order model and a beat scoreboard with timing checks.
module tb_nf10_axis_rr_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int UW = 16;
    localparam int SW = DW / 8;
    localparam int GW = 2;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP*SW-1:0]  s_tstrb;
    logic [NP*UW-1:0]  s_tuser;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tready;
    logic [NP-1:0]     s_tlast;
    logic [DW-1:0]     m_tdata;
    logic [SW-1:0]     m_tstrb;
    logic [UW-1:0]     m_tuser;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic [GW-1:0]     grant;
    logic              busy;

    always #5 clk = ~clk;

    nf10_axis_rr_arbiter #(
        .C_NUM_PORTS  (NP),
        .C_DATA_WIDTH (DW),
        .C_USER_WIDTH (UW)
    ) dut (
        .axi_aclk      (clk),
        .axi_resetn    (resetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .grant         (grant),
        .busy          (busy)
    );

    typedef struct packed {
        logic [1:0]    gap;   // cycles tvalid stays low before this beat
        logic [GW-1:0] port;
        logic          last;
        logic [UW-1:0] user;
        logic [SW-1:0] strb;
        logic [DW-1:0] data;
    } beat_t;
    localparam int BW = $bits(beat_t);

    beat_t          src_q[NP][$];
    beat_t          mdl_q[NP][$];
    logic [BW-1:0]  exp_q[$];
    int             bubble[NP];
    logic           rdy_q[$];
    bit             rand_ready;
    int             hs_cyc_q[$];
    int             model_last;
    int             checks;
    int             failures;

    task automatic drive_inputs();
        beat_t b;
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() > 0) begin
                b = src_q[p][0];
                s_tvalid[p] = (bubble[p] == 0);
            end else begin
                b = '0;
                s_tvalid[p] = 1'b0;
            end
            s_tdata[p*DW +: DW] = b.data;
            s_tstrb[p*SW +: SW] = b.strb;
            s_tuser[p*UW +: UW] = b.user;
            s_tlast[p]          = b.last;
        end
    endtask

    task automatic set_ready();
        if (rdy_q.size() > 0) m_tready = rdy_q.pop_front();
        else if (rand_ready)  m_tready = ($urandom_range(0, 3) != 0);
        else                  m_tready = 1'b1;
    endtask

    task automatic add_pkt(input int p, input int nb, input int max_gap);
        beat_t b;
        for (int i = 0; i < nb; i++) begin
            b.port = GW'(p);
            b.data = $urandom;
            b.strb = SW'($urandom);
            b.user = UW'($urandom);
            b.last = (i == nb - 1);
            b.gap  = (i == 0) ? 2'd0 : 2'($urandom_range(0, max_gap));
            src_q[p].push_back(b);
            mdl_q[p].push_back(b);
        end
    endtask

    // Packet order: with every loaded packet pending, each decision takes the
    // next port after the previous winner that still has packets.
    task automatic build_expected();
        bit    any;
        int    p;
        beat_t b;
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            p   = 0;
            for (int k = 1; k <= NP; k++) begin
                if (!any && mdl_q[(model_last + k) % NP].size() > 0) begin
                    p   = (model_last + k) % NP;
                    any = 1'b1;
                end
            end
            if (any) begin
                do begin
                    b = mdl_q[p].pop_front();
                    exp_q.push_back(b);
                end while (!b.last);
                model_last = p;
            end
        end
    endtask

    task automatic clear_all();
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            mdl_q[p].delete();
            bubble[p] = 0;
        end
        exp_q.delete();
        rdy_q.delete();
        hs_cyc_q.delete();
        m_tready = 1'b1;
        drive_inputs();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn     = 1'b1;
        model_last = NP - 1;
    endtask

    // Cycle engine: cycle 0 is the first cycle the loaded sources are visible.
    task automatic run_traffic(input int max_cyc, input int stop_hs);
        int            cyc;
        int            nhs;
        bit            prev_last_acc;
        bit            prev_stall;
        logic [DW+SW+UW:0] prev_out;
        logic [NP-1:0] hs;
        logic [NP-1:0] exp_sr;
        beat_t         e;
        beat_t         nb;
        cyc = 0; nhs = 0; prev_last_acc = 1'b0; prev_stall = 1'b0; prev_out = '0;
        @(posedge clk); #1;
        set_ready();
        drive_inputs();
        while (exp_q.size() > 0 && nhs < stop_hs && cyc < max_cyc) begin
            @(negedge clk);
            e = beat_t'(exp_q[0]);
            if (prev_last_acc) begin
                checks++;
                if (m_tvalid !== 1'b0 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_gap cyc=%0d: tvalid=%b busy=%b, expected 0 0", cyc, m_tvalid, busy);
                end
            end
            if (prev_stall) begin
                checks++;
                if ({m_tvalid, m_tlast, m_tuser, m_tstrb, m_tdata} !== {1'b1, prev_out}) begin
                    failures++;
                    $display("FAIL hold cyc=%0d: got %h expected %h", cyc,
                             {m_tvalid, m_tlast, m_tuser, m_tstrb, m_tdata}, {1'b1, prev_out});
                end
            end
            exp_sr = (busy === 1'b1) ? (NP'(m_tready) << e.port) : '0;
            checks++;
            if (s_tready !== exp_sr) begin
                failures++;
                $display("FAIL s_tready cyc=%0d: got %b expected %b", cyc, s_tready, exp_sr);
            end
            if (busy === 1'b1) begin
                checks++;
                if (grant !== e.port) begin
                    failures++;
                    $display("FAIL grant cyc=%0d: got %0d expected %0d", cyc, grant, e.port);
                end
            end
            hs            = s_tvalid & s_tready;
            prev_last_acc = (m_tvalid & m_tready & m_tlast) === 1'b1;
            prev_stall    = (m_tvalid & ~m_tready) === 1'b1;
            prev_out      = {m_tlast, m_tuser, m_tstrb, m_tdata};
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                void'(exp_q.pop_front());
                checks++;
                if ({m_tlast, m_tuser, m_tstrb, m_tdata} !== {e.last, e.user, e.strb, e.data}) begin
                    failures++;
                    $display("FAIL beat cyc=%0d port=%0d: got %h expected %h", cyc, e.port,
                             {m_tlast, m_tuser, m_tstrb, m_tdata}, {e.last, e.user, e.strb, e.data});
                end
                nhs++;
                hs_cyc_q.push_back(cyc);
            end
            @(posedge clk); #1;
            for (int p = 0; p < NP; p++) begin
                if (hs[p] === 1'b1) begin
                    void'(src_q[p].pop_front());
                    if (src_q[p].size() > 0) begin
                        nb = src_q[p][0];
                        bubble[p] = int'(nb.gap);
                    end
                end else if (bubble[p] > 0) begin
                    bubble[p]--;
                end
            end
            set_ready();
            drive_inputs();
            cyc++;
        end
        if (exp_q.size() > 0 && nhs < stop_hs) begin
            checks++;
            failures++;
            $display("FAIL timeout: %0d beats still expected after %0d cycles", exp_q.size(), cyc);
        end
    endtask

    task automatic check_hs_cycles(input string name, input int exp_cyc[$]);
        checks++;
        if (hs_cyc_q != exp_cyc) begin
            failures++;
            $display("FAIL %s: handshake cycles got %p expected %p", name, hs_cyc_q, exp_cyc);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({m_tvalid, m_tlast, s_tready, grant, busy} !== '0) begin
            failures++;
            $display("FAIL reset: {tvalid,tlast,s_tready,grant,busy} got %b expected all 0",
                     {m_tvalid, m_tlast, s_tready, grant, busy});
        end
    endtask

    task automatic test_single_port();
        do_reset();
        add_pkt(2, 3, 0);
        build_expected();
        run_traffic(50, 1000);
        check_hs_cycles("single_latency", '{1, 2, 3});
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL single_end: busy=%b tvalid=%b expected 0 0", busy, m_tvalid);
        end
    endtask

    task automatic test_all_ports();
        do_reset();
        for (int j = 0; j < 3; j++)
            for (int p = 0; p < NP; p++) add_pkt(p, 2, 0);
        build_expected();
        run_traffic(200, 1000);
        checks++;
        if (hs_cyc_q.size() != 24 || hs_cyc_q[hs_cyc_q.size()-1] != 35) begin
            failures++;
            $display("FAIL throughput: %0d beats, last at cycle %0d, expected 24 beats ending at 35",
                     hs_cyc_q.size(), (hs_cyc_q.size() > 0) ? hs_cyc_q[hs_cyc_q.size()-1] : -1);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (2) begin
            add_pkt(1, 2, 0);
            add_pkt(3, 1, 0);
            build_expected();
            run_traffic(50, 1000);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        add_pkt(0, 4, 0);
        build_expected();
        rdy_q = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        run_traffic(50, 1000);
        check_hs_cycles("backpressure", '{1, 4, 5, 6});
    endtask

    task automatic test_midpacket_bubble();
        beat_t b;
        do_reset();
        add_pkt(1, 1, 0);
        build_expected();
        run_traffic(20, 1000);
        hs_cyc_q.delete();
        add_pkt(0, 2, 0);
        add_pkt(2, 4, 0);
        b = src_q[2][1];
        b.gap = 2'd2;
        src_q[2][1] = b;
        build_expected();
        run_traffic(50, 1000);
        check_hs_cycles("bubble_hold", '{1, 4, 5, 6, 8, 9});
    endtask

    task automatic test_reset_midpacket();
        do_reset();
        add_pkt(2, 5, 0);
        build_expected();
        run_traffic(20, 1);
        @(negedge clk);
        checks++;
        if (m_tvalid !== 1'b1 || grant !== 2'd2) begin
            failures++;
            $display("FAIL beat2_present: tvalid=%b grant=%0d expected 1 2", m_tvalid, grant);
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        clear_all();
        model_last = NP - 1;
        @(negedge clk);
        checks++;
        if ({m_tvalid, s_tready, grant, busy} !== '0) begin
            failures++;
            $display("FAIL midreset: {tvalid,s_tready,grant,busy} got %b expected all 0",
                     {m_tvalid, s_tready, grant, busy});
        end
        add_pkt(3, 2, 0);
        add_pkt(0, 2, 0);
        build_expected();
        run_traffic(50, 1000);
    endtask

    task automatic test_random();
        do_reset();
        rand_ready = 1'b1;
        for (int p = 0; p < NP; p++)
            for (int j = $urandom_range(2, 4); j > 0; j--)
                add_pkt(p, $urandom_range(1, 4), 2);
        build_expected();
        run_traffic(2000, 100000);
        rand_ready = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rand_ready = 1'b0;
        resetn     = 1'b0;
        m_tready   = 1'b1;
        s_tdata = '0; s_tstrb = '0; s_tuser = '0; s_tvalid = '0; s_tlast = '0;
        test_reset();
        test_single_port();
        test_all_ports();
        test_wrap();
        test_backpressure();
        test_midpacket_bubble();
        test_reset_midpacket();
        repeat (3) test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
